// File: rtl/demux1to2_stream_pkg.sv
// Shared types for the 1:2 stream demultiplexer.
// Holds the FIFO state encoding and the port-select type and constants.
package demux_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } fifo_state_t;

    localparam int FIFO_DEPTH = 2;

    typedef logic port_sel_t;

    localparam port_sel_t PORT0 = 1'b0;
    localparam port_sel_t PORT1 = 1'b1;

endpackage

// File: rtl/demux1to2_stream_if.sv
// Handshake bundle of the 1:2 stream demux.
// Carries the input stream (data, sel, valid/ready), two output streams
// and the per-port delivered-beat counters.
// slave: the demux side; master: the producer/consumer side.
interface demux1to2_stream_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    import demux_pkg::*;

    logic [WIDTH-1:0] in_data;
    port_sel_t        in_sel;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;

    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;

    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport slave (
        input  in_data, in_sel, in_valid,
        output in_ready,
        output out0_data, out0_valid,
        input  out0_ready,
        output out1_data, out1_valid,
        input  out1_ready,
        output cnt0, cnt1
    );

    modport master (
        output in_data, in_sel, in_valid,
        input  in_ready,
        input  out0_data, out0_valid,
        output out0_ready,
        input  out1_data, out1_valid,
        output out1_ready,
        input  cnt0, cnt1
    );

endinterface

// File: rtl/demux1to2_stream_fifo2.sv
// Two-entry FIFO built from a head and a tail register.
// Ports: clk, rst (sync, active high), push/din, pop, full, valid, head.
// The head register is the output, so it stays stable while not popped.
module demux_fifo2
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] head
);

    fifo_state_t      state;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        head_q <= din;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        // Head leaves, new beat takes its place.
                        head_q <= din;
                    end else if (push) begin
                        tail_q <= din;
                        state  <= FULL;
                    end else if (pop) begin
                        state  <= EMPTY;
                    end
                end
                FULL: begin
                    // Producer is held off while full, so only pop matters.
                    if (pop) begin
                        head_q <= tail_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign full  = (state == FULL);
    assign valid = (state != EMPTY);
    assign head  = head_q;

endmodule

// File: rtl/demux1to2_stream.sv
// Steers one valid/ready stream to one of two buffered output streams.
// Ports: clk, rst (sync, active high), bus (slave side of the stream bundle).
module demux1to2_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    demux1to2_stream_if.slave  bus
);

    logic             full0;
    logic             full1;
    logic             valid0;
    logic             valid1;
    logic [WIDTH-1:0] head0;
    logic [WIDTH-1:0] head1;
    logic             sel_full;
    logic             ready;
    logic             accept;
    logic             push0;
    logic             push1;
    logic             pop0;
    logic             pop1;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    // Readiness looks only at the addressed port's registered full flag,
    // never at the consumers, so there is no ready path through the block.
    assign sel_full = (bus.in_sel == PORT1) ? full1 : full0;
    assign ready    = !rst && !sel_full;
    assign accept   = bus.in_valid && ready;

    assign push0 = accept && (bus.in_sel == PORT0);
    assign push1 = accept && (bus.in_sel == PORT1);
    assign pop0  = valid0 && bus.out0_ready;
    assign pop1  = valid1 && bus.out1_ready;

    demux_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
        .clk   (clk),
        .rst   (rst),
        .push  (push0),
        .din   (bus.in_data),
        .pop   (pop0),
        .full  (full0),
        .valid (valid0),
        .head  (head0)
    );

    demux_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (push1),
        .din   (bus.in_data),
        .pop   (pop1),
        .full  (full1),
        .valid (valid1),
        .head  (head1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (pop0) cnt0_q <= cnt0_q + 1'b1;
            if (pop1) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out0_data  = head0;
    assign bus.out0_valid = valid0;
    assign bus.out1_data  = head1;
    assign bus.out1_valid = valid1;
    assign bus.cnt0       = cnt0_q;
    assign bus.cnt1       = cnt1_q;

endmodule

// File: tb/tb_demux1to2_stream.sv
// Scoreboard bench for demux1to2_stream (CNT_W=4 to reach counter wrap).
// Driver queues expected beats; a monitor pops and compares on output beats.
module tb_demux1to2_stream;

    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    int   t0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] e0;
    logic [W-1:0] e1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    demux1to2_stream_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    demux1to2_stream #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the beat until the DUT is ready, then records it as expected.
    task automatic send(logic sel, logic [W-1:0] d);
        bit ok = 0;
        bus.in_sel   = sel;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk);
        end
        if (!ok) begin
            chk("send_timeout", 32'(ok), 1);
            bus.in_valid = 1'b0;
            sync();
        end else begin
            @(posedge clk);
            if (sel) q1.push_back(d);
            else     q0.push_back(d);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    // Output beats complete on the next rising edge; check them here.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out0_valid && bus.out0_ready) begin
                if (q0.size() == 0) begin
                    chk("out0_unexpected", q0.size(), 1);
                end else begin
                    e0 = q0.pop_front();
                    chk("out0_data", bus.out0_data, e0);
                end
            end
            if (bus.out1_valid && bus.out1_ready) begin
                if (q1.size() == 0) begin
                    chk("out1_unexpected", q1.size(), 1);
                end else begin
                    e1 = q1.pop_front();
                    chk("out1_data", bus.out1_data, e1);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_sel     = 1'b0;
        bus.in_data    = '0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        cycles(2);

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_v0", bus.out0_valid, 0);
        chk("rst_v1", bus.out1_valid, 0);
        chk("rst_d0", bus.out0_data, 0);
        chk("rst_d1", bus.out1_data, 0);
        chk("rst_cnt0", bus.cnt0, 0);
        chk("rst_cnt1", bus.cnt1, 0);
        sync();
        rst = 1'b0;
        cycles(1);

        // Two beats to port 0
        bus.out0_ready = 1'b1;
        send(0, 8'hA5);
        send(0, 8'h3C);
        @(negedge clk);
        chk("lat_valid", bus.out0_valid, 1);
        chk("lat_head", bus.out0_data, 8'h3C);
        chk("t1_v1", bus.out1_valid, 0);
        sync();
        cycles(3);
        chk("t1_cnt0", bus.cnt0, 2);
        chk("t1_cnt1", bus.cnt1, 0);

        // Port 1 backpressure
        send(1, 8'h11);
        send(1, 8'h22);
        bus.in_sel = 1'b1;
        @(negedge clk);
        chk("t2_full_ready", bus.in_ready, 0);
        chk("t2_v1", bus.out1_valid, 1);
        sync();
        bus.out1_ready = 1'b1;
        @(negedge clk);
        chk("t2_still_full", bus.in_ready, 0);
        sync();
        @(negedge clk);
        chk("t2_ready_rise", bus.in_ready, 1);
        sync();
        send(1, 8'h33);
        cycles(3);
        chk("t2_cnt1", bus.cnt1, 3);

        // Port 0 stalled, port 1 streams
        bus.out0_ready = 1'b0;
        send(0, 8'h51);
        send(0, 8'h52);
        bus.in_sel = 1'b0;
        @(negedge clk);
        chk("t3_p0_ready", bus.in_ready, 0);
        sync();
        t0 = cyc;
        for (int i = 0; i < 6; i++) send(1, 8'h60 + 8'(i));
        chk("t3_p1_rate", 32'(cyc - t0), 6);
        @(negedge clk);
        chk("t3_p0_valid", bus.out0_valid, 1);
        chk("t3_p0_stable", bus.out0_data, 8'h51);
        sync();
        bus.out0_ready = 1'b1;
        cycles(4);
        chk("t3_cnt0", bus.cnt0, 4);
        chk("t3_cnt1", bus.cnt1, 9);

        // Simultaneous push/pop at occupancy 1
        bus.out0_ready = 1'b0;
        send(0, 8'h40);
        bus.out0_ready = 1'b1;
        t0 = cyc;
        for (int i = 1; i <= 10; i++) send(0, 8'h40 + 8'(i));
        chk("t4_rate", 32'(cyc - t0), 10);
        @(negedge clk);
        chk("t4_valid", bus.out0_valid, 1);
        chk("t4_head", bus.out0_data, 8'h4A);
        sync();
        cycles(3);
        chk("t4_cnt0", bus.cnt0, 15);

        // Alternating ports, both consumers ready
        bus.out1_ready = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 6; i++) send(i[0], 8'h70 + 8'(i));
        chk("alt_rate", 32'(cyc - t0), 6);
        cycles(3);
        chk("alt_cnt0_wrap", bus.cnt0, 2);
        chk("alt_cnt1", bus.cnt1, 12);

        // Flush by reset
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        send(0, 8'h81);
        send(0, 8'h82);
        send(1, 8'h91);
        send(1, 8'h92);
        @(negedge clk);
        chk("t6_v0", bus.out0_valid, 1);
        chk("t6_v1", bus.out1_valid, 1);
        sync();
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        bus.in_sel = 1'b0;
        @(negedge clk);
        chk("t6_rst_ready", bus.in_ready, 0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_v0_clr", bus.out0_valid, 0);
        chk("t6_v1_clr", bus.out1_valid, 0);
        chk("t6_cnt0_clr", bus.cnt0, 0);
        chk("t6_cnt1_clr", bus.cnt1, 0);
        chk("t6_d0_clr", bus.out0_data, 0);
        chk("t6_ready", bus.in_ready, 1);
        sync();
        cycles(3);

        // 17 beats on port 1 with a 4-bit counter
        for (int i = 0; i < 17; i++) send(1, 8'hC0 + 8'(i));
        cycles(3);
        chk("t5_cnt1_wrap", bus.cnt1, 1);
        chk("t5_cnt0", bus.cnt0, 0);

        cycles(3);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux1to2_stream.md
# demux1to2_stream

- Routes one valid/ready input stream to one of two valid/ready output streams.
- Each beat is steered by a select bit that travels with the data.
- Each output is buffered by its own 2-entry FIFO, so a stalled output does not block beats bound for the other output.
- Counterpart of the combinational 2:1 mux: it fans a shared stream out to two consumers, with handshaking and per-port beat counters.

## Interface
- WIDTH, 8, data bits per beat
- CNT_W, 8, width of each per-port delivered-beat counter
- clk  input  1  rising-edge clock for all state
- rst  input  1  synchronous active-high reset
- in_data  input  WIDTH  input beat payload
- in_sel  input  1  destination of the beat: 0 selects out0, 1 selects out1
- in_valid  input  1  input beat present
- in_ready  output  1  block accepts the beat this cycle
- out0_data / out1_data  output  WIDTH  head-of-FIFO payload
- out0_valid / out1_valid  output  1  port FIFO non-empty
- out0_ready / out1_ready  input  1  consumer accepts the head beat
- cnt0 / cnt1  output  CNT_W  beats delivered on each port, modulo 2^CNT_W

## Operation
- Input handshake is `in_valid && in_ready`.
- in_ready = !full[in_sel]. It depends combinationally on in_sel and on registered full flags only; it never depends on out*_ready.
- An accepted beat is pushed into FIFO[in_sel]. The other FIFO is untouched.
- Output handshake on port k is `outk_valid && outk_ready`. It pops FIFO[k] and increments cntk by 1, wrapping from 2^CNT_W-1 to 0.
- Each port FIFO has 2 entries and tracks occupancy 0..2.
  - State EMPTY (occ 0): push -> ONE.
  - State ONE (occ 1): push only -> FULL; pop only -> EMPTY; push and pop together -> ONE, with the head replaced by the next entry.
  - State FULL (occ 2): pop -> ONE. No push is possible because in_ready is 0.
- No bypass path: a beat is never presented on an output in the same cycle it is accepted.
- Ordering is preserved per port. No ordering is guaranteed between ports.
- outk_data holds a stable value while outk_valid=1 and outk_ready=0.
- in_valid=0 means no push, whatever in_sel is. in_ready is still driven from in_sel, so it may toggle while idle.

## Timing
- Latency: a beat accepted on edge N is visible on the output (valid=1, data correct) in the cycle after edge N and can be popped on edge N+1 at the earliest.
- Throughput: 1 beat/cycle sustained into each port whose consumer holds ready=1. Alternating in_sel with both consumers ready also sustains 1 beat/cycle.
- Reset values, applied whenever rst=1 at a clock edge:
  - both FIFOs empty, out0_valid=out1_valid=0
  - cnt0=cnt1=0
  - out*_data = 0
- While rst=1, in_ready=0, even though the FIFOs are empty.
- Reset mid-operation flushes all buffered beats; they are lost, not delivered. Counters clear in the same edge.
- Push into port k while port k pops in the same cycle at occ 1: both take effect and occ stays 1. A push into one port and a pop from the other are independent.
- A counter wrap and a reset on the same edge: reset wins and the counter reads 0.

## Structure
- Shared package demux_pkg holds:
  - `typedef enum logic [1:0] {EMPTY, ONE, FULL} fifo_state_t`
  - `localparam int FIFO_DEPTH = 2`
  - `typedef logic port_sel_t`, with constants PORT0=0 and PORT1=1
- One sub-module, demux_fifo2: a parameterised 2-entry FIFO (WIDTH) with push, pop, full, and valid/head outputs, instantiated twice.
- The top level holds the in_sel steering, the in_ready mux and the two counters.

## Test plan
- Reset, then drive in_sel=0 with data 0xA5, 0x3C on consecutive cycles, out0_ready=1 -> out0 delivers 0xA5 then 0x3C, each 1 cycle after acceptance. out1_valid stays 0. cnt0=2, cnt1=0.
- out1_ready=0, send 3 beats with in_sel=1 -> first two accepted, in_ready=0 on the third. Raise out1_ready -> in_ready rises the cycle after the first pop. Order is preserved.
- Hold out0_ready=0 and fill port 0, then send in_sel=1 beats with out1_ready=1 -> port-1 traffic flows at 1 beat/cycle, unaffected by the stall on port 0.
- Port 0 at occ 1, push and pop on the same cycle for 10 cycles with incrementing data -> occ stays 1, out0_valid stays 1, all data appears in order.
- CNT_W=4: deliver 17 beats on port 1 -> cnt1 reads 1 after wrapping.
- Fill both FIFOs, assert rst for one cycle -> both valids are 0, both counters are 0, in_ready is 0 during reset and 1 afterwards, and no stale beat is ever emitted.
